// File: rtl/mem_io_responder.sv
// Byte-wide RAM responder with a memory-mapped UART window (TX/RX FIFOs, status)
// and a simulation-finish strobe, all decoded from a single 32-bit address bus.
module mem_io_responder #(
   parameter int unsigned RAM_ADDR_W = 17,
   parameter int unsigned FIFO_AW    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        ram_rw_select_in,
   input  logic [31:0] ram_addr_in,
   input  logic [7:0]  ram_data_in,
   output logic [7:0]  ram_data_out,
   output logic        uart_full_out,
   output logic        tx_valid_out,
   output logic [7:0]  tx_data_out,
   input  logic        tx_ready_in,
   input  logic        rx_valid_in,
   input  logic [7:0]  rx_data_in,
   output logic        rx_ready_out,
   output logic        sim_finish_out
);

   localparam int unsigned RAM_DEPTH  = 1 << RAM_ADDR_W;
   localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W      = FIFO_AW + 1;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);

   logic [7:0]          r_ram    [RAM_DEPTH];
   logic [7:0]          r_tx_mem [FIFO_DEPTH];
   logic [7:0]          r_rx_mem [FIFO_DEPTH];

   logic [7:0]          r_rd_data;
   logic                r_uart_full;
   logic                r_tx_valid;
   logic [7:0]          r_tx_data;
   logic                r_rx_ready;
   logic                r_sim_finish;
   logic                r_ovf;

   logic [FIFO_AW-1:0]  r_tx_wptr;
   logic [FIFO_AW-1:0]  r_tx_rptr;
   logic [CNT_W-1:0]    r_tx_count;
   logic [FIFO_AW-1:0]  r_rx_wptr;
   logic [FIFO_AW-1:0]  r_rx_rptr;
   logic [CNT_W-1:0]    r_rx_count;

   logic                w_io;
   logic                w_reg0;
   logic                w_reg4;
   logic                w_bus_wr;
   logic                w_bus_rd;
   logic                w_ram_wr;
   logic [RAM_ADDR_W-1:0] w_ram_idx;
   logic                w_tx_full;
   logic                w_tx_wr_req;
   logic                w_tx_push;
   logic                w_tx_ovf;
   logic                w_tx_pop;
   logic [FIFO_AW-1:0]  w_tx_rptr_nxt;
   logic [CNT_W-1:0]    w_tx_count_nxt;
   logic [7:0]          w_tx_head_nxt;
   logic                w_rx_empty;
   logic                w_rx_push;
   logic                w_rx_pop;
   logic [CNT_W-1:0]    w_rx_count_nxt;
   logic [7:0]          w_rd_data;
   logic                w_unused;

   // Address decode: the IO window is selected by bits [17:16], registers by the low half-word.
   assign w_io      = (ram_addr_in[17:16] == 2'b11);
   assign w_reg0    = (ram_addr_in[15:0] == 16'h0000);
   assign w_reg4    = (ram_addr_in[15:0] == 16'h0004);
   assign w_bus_wr  = rdy & ram_rw_select_in;
   assign w_bus_rd  = rdy & ~ram_rw_select_in;
   assign w_ram_wr  = w_bus_wr & ~w_io;
   assign w_ram_idx = ram_addr_in[RAM_ADDR_W-1:0];
   assign w_unused  = ^ram_addr_in[31:18];

   // TX FIFO control; a write while full is dropped and latches the overflow flag.
   assign w_tx_full      = (r_tx_count == CNT_FULL);
   assign w_tx_wr_req    = w_bus_wr & w_io & w_reg0;
   assign w_tx_push      = w_tx_wr_req & ~w_tx_full;
   assign w_tx_ovf       = w_tx_wr_req & w_tx_full;
   assign w_tx_pop       = r_tx_valid & tx_ready_in;
   assign w_tx_rptr_nxt  = r_tx_rptr + FIFO_AW'(w_tx_pop);
   assign w_tx_count_nxt = r_tx_count + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);
   // Bypass the incoming byte when it lands directly at the new head slot.
   assign w_tx_head_nxt  = (w_tx_push && (r_tx_wptr == w_tx_rptr_nxt)) ?
                           ram_data_in : r_tx_mem[w_tx_rptr_nxt];

   // RX FIFO control; bus-side pops of an empty FIFO are suppressed.
   assign w_rx_empty     = (r_rx_count == '0);
   assign w_rx_push      = rx_valid_in & r_rx_ready;
   assign w_rx_pop       = w_bus_rd & w_io & w_reg0 & ~w_rx_empty;
   assign w_rx_count_nxt = r_rx_count + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);

   // Read-data select for the current bus address.
   always_comb begin
      w_rd_data = 8'h00;
      if (!w_io) begin
         w_rd_data = r_ram[w_ram_idx];
      end else if (w_reg0) begin
         if (!w_rx_empty) begin
            w_rd_data = r_rx_mem[r_rx_rptr];
         end
      end else if (w_reg4) begin
         w_rd_data = {5'b00000, r_ovf, w_rx_empty, w_tx_full};
      end
   end

   // Storage arrays carry no reset; RAM contents come from the external init mechanism.
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         r_ram[w_ram_idx] <= ram_data_in;
      end
      if (w_tx_push) begin
         r_tx_mem[r_tx_wptr] <= ram_data_in;
      end
      if (w_rx_push) begin
         r_rx_mem[r_rx_wptr] <= rx_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data    <= 8'h00;
         r_uart_full  <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= 8'h00;
         r_rx_ready   <= 1'b0;
         r_sim_finish <= 1'b0;
         r_ovf        <= 1'b0;
         r_tx_wptr    <= '0;
         r_tx_rptr    <= '0;
         r_tx_count   <= '0;
         r_rx_wptr    <= '0;
         r_rx_rptr    <= '0;
         r_rx_count   <= '0;
      end else begin
         if (w_bus_rd) begin
            r_rd_data <= w_rd_data;
         end
         r_sim_finish <= w_bus_wr & w_io & w_reg4;
         if (w_tx_ovf) begin
            r_ovf <= 1'b1;
         end
         r_tx_wptr   <= r_tx_wptr + FIFO_AW'(w_tx_push);
         r_tx_rptr   <= w_tx_rptr_nxt;
         r_tx_count  <= w_tx_count_nxt;
         r_tx_valid  <= (w_tx_count_nxt != '0);
         r_tx_data   <= w_tx_head_nxt;
         // Almost-full leaves room for one write already in flight.
         r_uart_full <= (w_tx_count_nxt >= CNT_AFULL);
         r_rx_wptr   <= r_rx_wptr + FIFO_AW'(w_rx_push);
         r_rx_rptr   <= r_rx_rptr + FIFO_AW'(w_rx_pop);
         r_rx_count  <= w_rx_count_nxt;
         r_rx_ready  <= (w_rx_count_nxt != CNT_FULL);
      end
   end

   assign ram_data_out   = r_rd_data;
   assign uart_full_out  = r_uart_full;
   assign tx_valid_out   = r_tx_valid;
   assign tx_data_out    = r_tx_data;
   assign rx_ready_out   = r_rx_ready;
   assign sim_finish_out = r_sim_finish;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed vector table, hand-written
// FIFO/reset sequences, then random traffic against a queue-based reference model.
module tb_mem_io_responder;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        ram_rw_select_in;
   logic [31:0] ram_addr_in;
   logic [7:0]  ram_data_in;
   logic [7:0]  ram_data_out;
   logic        uart_full_out;
   logic        tx_valid_out;
   logic [7:0]  tx_data_out;
   logic        tx_ready_in;
   logic        rx_valid_in;
   logic [7:0]  rx_data_in;
   logic        rx_ready_out;
   logic        sim_finish_out;

   mem_io_responder dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .ram_rw_select_in (ram_rw_select_in),
      .ram_addr_in      (ram_addr_in),
      .ram_data_in      (ram_data_in),
      .ram_data_out     (ram_data_out),
      .uart_full_out    (uart_full_out),
      .tx_valid_out     (tx_valid_out),
      .tx_data_out      (tx_data_out),
      .tx_ready_in      (tx_ready_in),
      .rx_valid_in      (rx_valid_in),
      .rx_data_in       (rx_data_in),
      .rx_ready_out     (rx_ready_out),
      .sim_finish_out   (sim_finish_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: byte memory, FIFO contents as queues, expected output registers.
   logic [7:0]  m_mem [int unsigned];
   logic [7:0]  m_txq [$];
   logic [7:0]  m_rxq [$];
   bit          m_ovf;
   logic [7:0]  e_dout;
   bit          e_full;
   bit          e_txv;
   bit          e_rxr;
   bit          e_sim;
   logic [7:0]  tx_got [$];

   typedef struct {
      logic        rdy;
      logic        rw;
      logic [31:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp_dout;
      logic        exp_sim;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_txq.delete();
      m_rxq.delete();
      m_ovf  = 1'b0;
      e_dout = 8'h00;
      e_full = 1'b0;
      e_txv  = 1'b0;
      e_rxr  = 1'b0;
      e_sim  = 1'b0;
   endtask

   // One clock edge of the reference model, evaluated from the inputs held across it.
   task automatic model_edge();
      bit          io;
      int unsigned idx;
      int unsigned off;
      int          txn;
      int          rxn;
      bit          tx_push;
      io      = (((ram_addr_in >> 16) & 32'h3) == 32'h3);
      idx     = ram_addr_in % 32'h20000;
      off     = ram_addr_in & 32'hFFFF;
      txn     = m_txq.size();
      rxn     = m_rxq.size();
      tx_push = 1'b0;
      e_sim   = 1'b0;
      if (rdy && !ram_rw_select_in) begin
         if (!io) e_dout = m_mem.exists(idx) ? m_mem[idx] : 8'h00;
         else if (off == 0) e_dout = (rxn > 0) ? m_rxq.pop_front() : 8'h00;
         else if (off == 4) e_dout = {5'b0, m_ovf, rxn == 0, txn == 8};
         else e_dout = 8'h00;
      end
      if (rdy && ram_rw_select_in) begin
         if (!io) m_mem[idx] = ram_data_in;
         else if (off == 0) begin
            if (txn == 8) m_ovf = 1'b1;
            else tx_push = 1'b1;
         end
         else if (off == 4) e_sim = 1'b1;
      end
      if (txn > 0 && tx_ready_in) void'(m_txq.pop_front());
      if (tx_push) m_txq.push_back(ram_data_in);
      if (rx_valid_in && e_rxr) m_rxq.push_back(rx_data_in);
      e_full = (m_txq.size() >= 7);
      e_txv  = (m_txq.size() > 0);
      e_rxr  = (m_rxq.size() != 8);
   endtask

   task automatic compare_all();
      chk("ram_data_out", ram_data_out, e_dout);
      chk("uart_full_out", uart_full_out, e_full);
      chk("tx_valid_out", tx_valid_out, e_txv);
      if (e_txv) chk("tx_data_out", tx_data_out, m_txq[0]);
      chk("rx_ready_out", rx_ready_out, e_rxr);
      chk("sim_finish_out", sim_finish_out, e_sim);
   endtask

   task automatic step(input logic r, input logic rw, input logic [31:0] a, input logic [7:0] d,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
      rdy              = r;
      ram_rw_select_in = rw;
      ram_addr_in      = a;
      ram_data_in      = d;
      tx_ready_in      = txr;
      rx_valid_in      = rxv;
      rx_data_in       = rxd;
      #1;
      if (tx_valid_out && tx_ready_in) tx_got.push_back(tx_data_out);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b0;
      ram_rw_select_in = 1'b0;
      ram_addr_in = 32'h0;
      ram_data_in = 8'h00;
      tx_ready_in = 1'b0;
      rx_valid_in = 1'b0;
      rx_data_in  = 8'h00;
      model_reset();

      tbl.push_back('{1'b1, 1'b1, 32'h0000_0010, 8'hA5, 8'h00, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0000_0100, 8'h11, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0000_0101, 8'h22, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0000_0102, 8'h33, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0000_0103, 8'h44, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0100, 8'h00, 8'h11, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0101, 8'h00, 8'h22, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0102, 8'h00, 8'h33, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0103, 8'h00, 8'h44, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 32'h0000_0010, 8'h00, 8'h44, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 32'h0003_0004, 8'h00, 8'h44, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0003_0004, 8'h00, 8'h44, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 32'h0003_0008, 8'h00, 8'h00, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0003_0004, 8'h00, 8'h02, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 32'h0000_0010, 8'hFF, 8'h02, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 32'h0003_0010, 8'h77, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0003_0010, 8'h00, 8'h00, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'h0002_0010, 8'h00, 8'hA5, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'hFFFC_0103, 8'h00, 8'h44, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 32'hABCF_0000, 8'h00, 8'h00, 1'b0});

      // Reset state
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_data_out", ram_data_out, 8'h00);
      chk("rst_uart_full", uart_full_out, 1'b0);
      chk("rst_tx_valid", tx_valid_out, 1'b0);
      chk("rst_tx_data", tx_data_out, 8'h00);
      chk("rst_rx_ready", rx_ready_out, 1'b0);
      chk("rst_sim_finish", sim_finish_out, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Directed vector table
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rdy, tbl[i].rw, tbl[i].addr, tbl[i].data, 1'b0, 1'b0, 8'h00);
         chk($sformatf("tbl%0d_dout", i), ram_data_out, tbl[i].exp_dout);
         chk($sformatf("tbl%0d_sim", i), sim_finish_out, tbl[i].exp_sim);
      end

      // TX fill to overflow, then drain in order
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 32'h0003_0000, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00);
         if (i == 5) chk("uart_full_after6", uart_full_out, 1'b0);
      end
      chk("uart_full_after7", uart_full_out, 1'b1);
      step(1'b1, 1'b1, 32'h0003_0000, 8'hC7, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 32'h0003_0000, 8'hEE, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_overflow", ram_data_out, 8'h07);
      tx_got.delete();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);
         if (i == 0) chk("uart_full_cnt7", uart_full_out, 1'b1);
         if (i == 1) chk("uart_full_cnt6", uart_full_out, 1'b0);
      end
      chk("tx_drain_count", tx_got.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < tx_got.size()) chk($sformatf("tx_drain%0d", i), tx_got[i], 8'(8'hC0 + i));
      end
      chk("tx_empty_after_drain", tx_valid_out, 1'b0);

      // RX receive then bus reads, including read of empty FIFO
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'h41);
      step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'h42);
      step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_read1", ram_data_out, 8'h41);
      step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_read2", ram_data_out, 8'h42);
      step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_read_empty", ram_data_out, 8'h00);

      // Asynchronous reset in the middle of FIFO traffic
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'h0003_0000, 8'(8'h50 + i), 1'b0, 1'b1, 8'(8'h60 + i));
      end
      step(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h63);
      step(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h64);
      #2 rst = 1'b0;
      #1;
      chk("arst_ram_data_out", ram_data_out, 8'h00);
      chk("arst_uart_full", uart_full_out, 1'b0);
      chk("arst_tx_valid", tx_valid_out, 1'b0);
      chk("arst_tx_data", tx_data_out, 8'h00);
      chk("arst_rx_ready", rx_ready_out, 1'b0);
      chk("arst_sim_finish", sim_finish_out, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_after_reset", ram_data_out, 8'h02);

      // Preload a RAM window, then random traffic against the model
      for (int k = 0; k < 64; k++) begin
         step(1'b1, 1'b1, 32'(k), 8'($urandom), 1'b0, 1'b0, 8'h00);
      end
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         int unsigned sel;
         sel = $urandom_range(0, 7);
         if (sel < 5) a = ($urandom << 18) | (32'($urandom_range(0, 1)) << 17) | 32'($urandom_range(0, 63));
         else if (sel < 7) a = ($urandom << 18) | 32'h0003_0000;
         else a = ($urandom << 18) | 32'h0003_0000 | (($urandom_range(0, 1) == 0) ? 32'h4 : 32'hC);
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 8'($urandom),
              1'($urandom), 1'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
